gf2_poly_div: RTL

GF2_POLY_DIV -- requirements
Module: gf2_poly_div

---
 rtl/gf2_poly_div_if.sv | 21 ++
 rtl/gf2_poly_div.sv | 80 ++++++++
 2 files changed

// File: rtl/gf2_poly_div_if.sv
// gf2_poly_div_if: operand/result handshake bundle for the GF(2) polynomial divider.
interface gf2_poly_div_if #(parameter int DW = 16);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [7:0]    divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [6:0]    remainder;
    logic          div_err;
    logic          chk_err;
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_err, chk_err
    );
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_err, chk_err
    );
endinterface

// File: rtl/gf2_poly_div.sv
// gf2_poly_div: bit-serial carry-less divider, DW dividend bits by an 8-bit divisor, MSB first.
// Define GF2_DIV_SELFCHECK_EN to re-multiply the result and flag mismatches on chk_err.
module gf2_poly_div #(parameter int DW = 16) (
    input logic clk,
    input logic rst,
    gf2_poly_div_if.slave bus
);
    localparam int CW = $clog2(DW);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t        r_state, w_next;
    logic [DW-1:0] r_dividend, r_quot, w_q_n;
    logic [7:0]    r_divisor, w_shift;
    logic [6:0]    r_rem, w_red;
    logic [CW-1:0] r_idx;
    logic [2:0]    w_d;
    logic          r_div_err, r_chk_err, w_acc, w_hit, w_chk;
    always_comb begin
        w_d = '0;
        for (int k = 0; k < 8; k++) if (r_divisor[k]) w_d = 3'(k);
    end
    assign w_acc   = (r_state == IDLE) && bus.in_valid;
    assign w_shift = {r_rem, r_dividend[r_idx]};
    assign w_hit   = w_shift[w_d];
    assign w_red   = w_hit ? w_shift[6:0] ^ r_divisor[6:0] : w_shift[6:0];
    assign w_q_n   = {r_quot[DW-2:0], w_hit};
`ifdef GF2_DIV_SELFCHECK_EN
    logic [DW+6:0] w_prod;
    always_comb begin
        w_prod = '0;
        for (int k = 0; k < 8; k++) if (r_divisor[k]) w_prod = w_prod ^ ({7'b0, w_q_n} << k);
    end
    // Product bits above DW mean the quotient cannot reproduce a DW-bit dividend.
    assign w_chk = (|w_prod[DW+6:DW]) | ((w_prod[DW-1:0] ^ {{(DW-7){1'b0}}, w_red}) != r_dividend);
`else
    assign w_chk = 1'b0;
`endif
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.in_valid ? ((bus.divisor == '0) ? DONE : BUSY) : IDLE;
            BUSY:    w_next = (r_idx == '0) ? DONE : BUSY;
            DONE:    w_next = bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_idx      <= '0;
            r_div_err  <= 1'b0;
            r_chk_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_dividend <= bus.dividend;
                r_divisor  <= bus.divisor;
                r_quot     <= '0;
                r_rem      <= '0;
                r_idx      <= CW'(DW - 1);
                r_div_err  <= (bus.divisor == '0);
                r_chk_err  <= 1'b0;
            end else if (r_state == BUSY) begin
                r_rem  <= w_red;
                r_quot <= w_q_n;
                r_idx  <= r_idx - 1'b1;
                if (r_idx == '0) r_chk_err <= w_chk;
            end
        end
    end
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.div_err   = r_div_err;
    assign bus.chk_err   = r_chk_err;
endmodule
